// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
//   Shared definitions for the RV32I ALU decode path: alu_control codes,
//   opcode/funct3/funct7 constants and the decoded-entry struct that the
//   decoder produces, the decode stage buffers and the ALU consumes.
//   No ports (package).
package riscv_alu_pkg;

  // ALU operation codes carried on alu_control; zero means "no operation"
  localparam logic [5:0] ALU_NONE  = 6'h00;
  localparam logic [5:0] ALU_ADD   = 6'h01;
  localparam logic [5:0] ALU_SUB   = 6'h02;
  localparam logic [5:0] ALU_SLL   = 6'h03;
  localparam logic [5:0] ALU_SLT   = 6'h04;
  localparam logic [5:0] ALU_SLTU  = 6'h05;
  localparam logic [5:0] ALU_XOR   = 6'h06;
  localparam logic [5:0] ALU_SRL   = 6'h07;
  localparam logic [5:0] ALU_SRA   = 6'h08;
  localparam logic [5:0] ALU_OR    = 6'h09;
  localparam logic [5:0] ALU_AND   = 6'h0A;
  localparam logic [5:0] ALU_ADDI  = 6'h0B;
  localparam logic [5:0] ALU_SLLI  = 6'h0C;
  localparam logic [5:0] ALU_SLTI  = 6'h0D;
  localparam logic [5:0] ALU_ANDI  = 6'h0E;
  localparam logic [5:0] ALU_XORI  = 6'h0F;
  localparam logic [5:0] ALU_SRLI  = 6'h10;
  localparam logic [5:0] ALU_SLTIU = 6'h11;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded instruction as it travels from decode to the ALU
  typedef struct packed {
    logic [5:0]  aluControl;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] immVal;
    logic        useImm;
    logic        regWrite;
    logic        illegal;
  } decodedEntry_t;

endpackage

// File: rtl/alu_op_decoder.sv
// AluOpDecoder (module alu_op_decoder)
//   Purely combinational decode of one RV32I OP / OP-IMM word into a
//   decodedEntry_t. Anything that is not a legal OP or OP-IMM encoding is
//   flagged illegal with control, write-enable and immediate forced to zero.
// Ports
//   i_instr  in   32  instruction word
//   o_entry  out  decodedEntry_t  decoded fields and flags
module alu_op_decoder
  import riscv_alu_pkg::*;
(
  input  logic [31:0]   i_instr,
  output decodedEntry_t o_entry
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [5:0] w_code;
  logic       w_isImm;
  logic       w_isShiftImm;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Pick the ALU code from opcode/funct3/funct7. Any encoding that does not
  // land on a code leaves w_code at ALU_NONE, which is what marks it illegal.
  always_comb begin
    w_code       = ALU_NONE;
    w_isImm      = 1'b0;
    w_isShiftImm = 1'b0;
    if (w_opcode == OPCODE_OP) begin
      unique case (w_funct3)
        F3_ADD_SUB: begin
          if (w_funct7 == F7_BASE)     w_code = ALU_ADD;
          else if (w_funct7 == F7_ALT) w_code = ALU_SUB;
        end
        F3_SLL:  if (w_funct7 == F7_BASE) w_code = ALU_SLL;
        F3_SLT:  if (w_funct7 == F7_BASE) w_code = ALU_SLT;
        F3_SLTU: if (w_funct7 == F7_BASE) w_code = ALU_SLTU;
        F3_XOR:  if (w_funct7 == F7_BASE) w_code = ALU_XOR;
        F3_SR: begin
          if (w_funct7 == F7_BASE)     w_code = ALU_SRL;
          else if (w_funct7 == F7_ALT) w_code = ALU_SRA;
        end
        F3_OR:   if (w_funct7 == F7_BASE) w_code = ALU_OR;
        F3_AND:  if (w_funct7 == F7_BASE) w_code = ALU_AND;
        default: w_code = ALU_NONE;
      endcase
    end else if (w_opcode == OPCODE_OP_IMM) begin
      w_isImm = 1'b1;
      unique case (w_funct3)
        F3_ADD_SUB: w_code = ALU_ADDI;
        F3_SLL: begin
          w_isShiftImm = 1'b1;
          if (w_funct7 == F7_BASE) w_code = ALU_SLLI;
        end
        F3_SLT:  w_code = ALU_SLTI;
        F3_SLTU: w_code = ALU_SLTIU;
        F3_XOR:  w_code = ALU_XORI;
        F3_SR: begin
          w_isShiftImm = 1'b1;
          if (w_funct7 == F7_BASE)     w_code = ALU_SRLI;
          else if (w_funct7 == F7_ALT) w_code = ALU_SRA;
        end
        F3_OR:   w_code = ALU_OR;
        F3_AND:  w_code = ALU_ANDI;
        default: w_code = ALU_NONE;
      endcase
    end
  end

  // Assemble the entry. Register fields always pass through; an illegal word
  // keeps use_imm low so rs2 still shows the raw instr[24:20] field.
  always_comb begin
    o_entry            = '0;
    o_entry.rs1Addr    = i_instr[19:15];
    o_entry.rs2Addr    = i_instr[24:20];
    o_entry.rdAddr     = i_instr[11:7];
    o_entry.illegal    = (w_code == ALU_NONE);
    if (w_code != ALU_NONE) begin
      o_entry.aluControl = w_code;
      o_entry.regWrite   = 1'b1;
      if (w_isImm) begin
        o_entry.useImm  = 1'b1;
        o_entry.rs2Addr = 5'd0;
        if (w_isShiftImm) o_entry.immVal = {27'd0, i_instr[24:20]};
        else              o_entry.immVal = {{20{i_instr[31]}}, i_instr[31:20]};
      end
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// AluDecodeStage (module alu_decode_stage)
//   Registered decode stage in front of the register file / ALU. Decodes the
//   incoming word combinationally, then holds results in a head register plus
//   one skid register so the stage runs at full throughput with a registered
//   in_ready. Counts accepted illegal words with a saturating counter.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all buffered entries
//   in_valid/in_ready/in_instr    upstream handshake and instruction
//   out_valid/out_ready           downstream handshake
//   alu_control, rs1_addr, rs2_addr, rd_addr, imm_val_r, use_imm,
//   reg_write, illegal            decoded head entry
//   illegal_count     saturating count of accepted illegal words
module alu_decode_stage
  import riscv_alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alu_control,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm_val_r,
  output logic             use_imm,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occState_t;

  occState_t        r_state;
  decodedEntry_t    r_head;
  decodedEntry_t    r_skid;
  logic             r_inReady;
  logic             r_outValid;
  logic [CNT_W-1:0] r_illegalCount;

  decodedEntry_t    w_dec;
  logic             w_accept;
  logic             w_pop;

  alu_op_decoder u_decoder (
    .i_instr (in_instr),
    .o_entry (w_dec)
  );

  // A flush cycle ignores in_valid entirely, so it can neither push nor count.
  assign w_accept = in_valid & r_inReady & ~flush;
  assign w_pop    = r_outValid & out_ready;

  // Occupancy FSM plus head/skid data. in_ready and out_valid are kept as
  // their own flops, updated on every transition, so both handshake outputs
  // come straight from registers. Consumers only ever see the head; the skid
  // register catches the one extra word accepted while the head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= EMPTY;
      r_head         <= '0;
      r_skid         <= '0;
      r_inReady      <= 1'b1;
      r_outValid     <= 1'b0;
      r_illegalCount <= '0;
    end else begin
      if (w_accept && w_dec.illegal && (r_illegalCount != '1))
        r_illegalCount <= r_illegalCount + CNT_W'(1);

      if (flush) begin
        r_state    <= EMPTY;
        r_inReady  <= 1'b1;
        r_outValid <= 1'b0;
      end else begin
        unique case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_head     <= w_dec;
              r_state    <= ONE;
              r_outValid <= 1'b1;
            end
          end
          ONE: begin
            if (w_accept && w_pop) begin
              r_head <= w_dec;
            end else if (w_accept) begin
              r_skid    <= w_dec;
              r_state   <= FULL;
              r_inReady <= 1'b0;
            end else if (w_pop) begin
              r_state    <= EMPTY;
              r_outValid <= 1'b0;
            end
          end
          FULL: begin
            if (w_pop) begin
              r_head    <= r_skid;
              r_state   <= ONE;
              r_inReady <= 1'b1;
            end
          end
          default: begin
            r_state    <= EMPTY;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready      = r_inReady;
  assign out_valid     = r_outValid;
  assign alu_control   = r_head.aluControl;
  assign rs1_addr      = r_head.rs1Addr;
  assign rs2_addr      = r_head.rs2Addr;
  assign rd_addr       = r_head.rdAddr;
  assign imm_val_r     = r_head.immVal;
  assign use_imm       = r_head.useImm;
  assign reg_write     = r_head.regWrite;
  assign illegal       = r_head.illegal;
  assign illegal_count = r_illegalCount;

endmodule

// File: tb/tb_alu_decode_stage.sv
// TbAluDecodeStage (module tb_alu_decode_stage)
//   Self-checking bench for alu_decode_stage: directed instruction examples,
//   backpressure, flush, counter saturation and a randomized run, all checked
//   against a queue-based reference model of the stage.
module tb_alu_decode_stage;
  import riscv_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_control;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm_val_r;
  logic        use_imm;
  logic        reg_write;
  logic        illegal;
  logic [15:0] illegal_count;

  int assertCount = 0;
  int failCount   = 0;

  decodedEntry_t modelQ[$];
  logic [15:0]   modelCount = 16'd0;
  bit            modelJustReset = 1'b0;

  alu_decode_stage #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_control   (alu_control),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rd_addr       (rd_addr),
    .imm_val_r     (imm_val_r),
    .use_imm       (use_imm),
    .reg_write     (reg_write),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode built from code tables indexed by funct3
  function automatic decodedEntry_t refDecode(input logic [31:0] ins);
    logic [5:0] rCode[8];
    logic [5:0] iCode[8];
    decodedEntry_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] code;
    bit isR, isI, isShift;
    rCode = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10};
    iCode = '{6'd11, 6'd12, 6'd13, 6'd17, 6'd15, 6'd16, 6'd9, 6'd14};
    f3 = ins[14:12];
    f7 = ins[31:25];
    isR = (ins[6:0] == 7'h33);
    isI = (ins[6:0] == 7'h13);
    isShift = (f3 == 3'd1) || (f3 == 3'd5);
    code = 6'd0;
    if (isR) begin
      if (f7 == 7'h00) code = rCode[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 6'd2;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 6'd8;
    end else if (isI) begin
      if (!isShift || f7 == 7'h00) code = iCode[f3];
      else if (f7 == 7'h20 && f3 == 3'd5) code = 6'd8;
    end
    e = '0;
    e.rs1Addr = ins[19:15];
    e.rs2Addr = ins[24:20];
    e.rdAddr  = ins[11:7];
    e.illegal = (code == 6'd0);
    if (code != 6'd0) begin
      e.aluControl = code;
      e.regWrite   = 1'b1;
      if (isI) begin
        e.useImm  = 1'b1;
        e.rs2Addr = 5'd0;
        e.immVal  = isShift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
      end
    end
    return e;
  endfunction

  // Compare handshake, counter and head entry against the model
  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(modelQ.size() < 2));
    checkOutput("illegal_count", 32'(illegal_count), 32'(modelCount));
    if (modelJustReset) begin
      checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
      checkOutput("rst_imm", imm_val_r, 32'd0);
      checkOutput("rst_regs", 32'({rs1_addr, rs2_addr, rd_addr}), 32'd0);
      checkOutput("rst_flags", 32'({use_imm, reg_write, illegal}), 32'd0);
    end else if (modelQ.size() > 0) begin
      checkOutput("alu_control", 32'(alu_control), 32'(modelQ[0].aluControl));
      checkOutput("rs1_addr", 32'(rs1_addr), 32'(modelQ[0].rs1Addr));
      checkOutput("rs2_addr", 32'(rs2_addr), 32'(modelQ[0].rs2Addr));
      checkOutput("rd_addr", 32'(rd_addr), 32'(modelQ[0].rdAddr));
      checkOutput("imm_val_r", imm_val_r, modelQ[0].immVal);
      checkOutput("use_imm", 32'(use_imm), 32'(modelQ[0].useImm));
      checkOutput("reg_write", 32'(reg_write), 32'(modelQ[0].regWrite));
      checkOutput("illegal", 32'(illegal), 32'(modelQ[0].illegal));
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then check the DUT just after the edge
  task automatic applyStimulus();
    bit acc, pop;
    decodedEntry_t pending;
    acc = in_valid && (modelQ.size() < 2) && !flush;
    pop = (modelQ.size() > 0) && out_ready;
    pending = refDecode(in_instr);
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
      modelCount = 16'd0;
      modelJustReset = 1'b1;
    end else if (flush) begin
      modelQ.delete();
      modelJustReset = 1'b0;
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (acc) begin
        modelQ.push_back(pending);
        if (pending.illegal && modelCount != 16'hFFFF) modelCount = modelCount + 16'd1;
      end
      modelJustReset = 1'b0;
    end
    #1;
    checkAll();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 4)      r[6:0] = 7'h33;
    else if (sel < 8) r[6:0] = 7'h13;
    if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // add x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h002081B3;
    applyStimulus();
    checkOutput("add_ctrl", 32'(alu_control), 32'h01);
    checkOutput("add_regs", 32'({rs1_addr, rs2_addr, rd_addr}), 32'({5'd1, 5'd2, 5'd3}));
    checkOutput("add_wr", 32'(reg_write), 32'd1);
    out_ready = 1'b1; in_instr = 32'h407302B3;
    applyStimulus();
    checkOutput("sub_ctrl", 32'(alu_control), 32'h02);
    in_instr = 32'h40001033;
    applyStimulus();
    checkOutput("sll_alt_illegal", 32'(illegal), 32'd1);
    checkOutput("sll_alt_count", 32'(illegal_count), 32'd1);
    in_instr = 32'hFFF00093;
    applyStimulus();
    checkOutput("addi_ctrl", 32'(alu_control), 32'h0B);
    checkOutput("addi_imm", imm_val_r, 32'hFFFFFFFF);
    checkOutput("addi_use_imm", 32'(use_imm), 32'd1);
    in_instr = 32'h40315093;
    applyStimulus();
    checkOutput("srai_ctrl", 32'(alu_control), 32'h08);
    checkOutput("srai_imm", imm_val_r, 32'd3);
    in_valid = 1'b0;
    applyStimulus();

    // Backpressure: three cycles stalled with in_valid held
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = randInstr();
      applyStimulus();
    end
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

    // Flush while full with in_valid asserted
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000000;
    applyStimulus();
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    applyStimulus();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = randInstr();
      applyStimulus();
    end
    flush = 1'b0;

    // Counter saturation with a stream of all-zero (illegal) words
    rst = 1'b1; in_valid = 1'b0;
    applyStimulus();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h00000000;
    for (int i = 0; i < 65534; i++) applyStimulus();
    checkOutput("count_fffe", 32'(illegal_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("count_sat", 32'(illegal_count), 32'h0000FFFF);
    rst = 1'b1;
    applyStimulus();
    checkOutput("count_rst", 32'(illegal_count), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
